mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-pin bundle for mem_port_arbiter.
// The arbiter takes the slave view; requesters and the Memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 I_REQ;
    logic [WORD_SIZE-1:0] I_ADDR;
    logic                 I_ACK;
    logic [WORD_SIZE-1:0] I_DATA;

    logic                 D_REQ;
    logic                 D_WE;
    logic [WORD_SIZE-1:0] D_ADDR;
    logic [WORD_SIZE-1:0] D_WDATA;
    logic                 D_ACK;
    logic [WORD_SIZE-1:0] D_RDATA;

    logic                 ADDR_ERR;

    logic                 MEM_W;
    logic                 MEM_ON;
    logic [WORD_SIZE-1:0] MEM_ADDR;
    logic [WORD_SIZE-1:0] MEM_DIN;
    logic [WORD_SIZE-1:0] MEM_DOUT;

    modport slave (
        input  I_REQ, I_ADDR,
        input  D_REQ, D_WE, D_ADDR, D_WDATA,
        input  MEM_DOUT,
        output I_ACK, I_DATA,
        output D_ACK, D_RDATA,
        output ADDR_ERR,
        output MEM_W, MEM_ON, MEM_ADDR, MEM_DIN
    );

    modport master (
        output I_REQ, I_ADDR,
        output D_REQ, D_WE, D_ADDR, D_WDATA,
        output MEM_DOUT,
        input  I_ACK, I_DATA,
        input  D_ACK, D_RDATA,
        input  ADDR_ERR,
        input  MEM_W, MEM_ON, MEM_ADDR, MEM_DIN
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port Memory between the
// fetch stage and the data stage; each grant runs IDLE -> ACCESS -> DONE.
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_MAX  = 20
) (
    input  logic                   CLK,
    input  logic                   RST,
    mem_port_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [WORD_SIZE-1:0] ADDR_LIMIT = WORD_SIZE'(ADDR_MAX);
    localparam logic                 SEL_I      = 1'b0;
    localparam logic                 SEL_D      = 1'b1;

    function automatic logic addr_out_of_range(input logic [WORD_SIZE-1:0] a);
        return (a > ADDR_LIMIT);
    endfunction

    state_t               state_q,     state_d;
    logic                 sel_q,       sel_d;
    logic                 we_q,        we_d;
    logic [WORD_SIZE-1:0] addr_q,      addr_d;
    logic [WORD_SIZE-1:0] wdata_q,     wdata_d;
    logic                 bad_q,       bad_d;
    logic                 last_q,      last_d;
    logic [WORD_SIZE-1:0] i_data_q,    i_data_d;
    logic [WORD_SIZE-1:0] d_rdata_q,   d_rdata_d;
    logic                 addr_err_q,  addr_err_d;
    logic                 i_ack_q,     i_ack_d;
    logic                 d_ack_q,     d_ack_d;

    logic                 take_d_s;
    logic [WORD_SIZE-1:0] rd_word_s;
    logic                 mem_on_s;

    // Next-state and datapath decode for the three-state sequencer.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bad_d      = bad_q;
        last_d     = last_q;
        i_data_d   = i_data_q;
        d_rdata_d  = d_rdata_q;
        addr_err_d = addr_err_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        take_d_s   = 1'b0;
        rd_word_s  = {WORD_SIZE{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.I_REQ || bus.D_REQ) begin
                    // On a tie the requester that did not win last time goes first.
                    take_d_s = bus.D_REQ && (!bus.I_REQ || (last_q == SEL_I));
                    if (take_d_s) begin
                        sel_d   = SEL_D;
                        we_d    = bus.D_WE;
                        addr_d  = bus.D_ADDR;
                        wdata_d = bus.D_WDATA;
                    end else begin
                        sel_d   = SEL_I;
                        we_d    = 1'b0;
                        addr_d  = bus.I_ADDR;
                        wdata_d = wdata_q;
                    end
                    bad_d   = addr_out_of_range(addr_d);
                    last_d  = sel_d;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (bad_q) begin
                    rd_word_s  = {WORD_SIZE{1'b0}};
                    addr_err_d = 1'b1;
                end else begin
                    rd_word_s  = bus.MEM_DOUT;
                    addr_err_d = addr_err_q;
                end

                if (sel_q == SEL_D) begin
                    d_ack_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = rd_word_s;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    i_ack_d  = 1'b1;
                    i_data_d = rd_word_s;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request latches and response registers; last starts at D so I wins the first tie.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_I;
            we_q       <= 1'b0;
            addr_q     <= {WORD_SIZE{1'b0}};
            wdata_q    <= {WORD_SIZE{1'b0}};
            bad_q      <= 1'b0;
            last_q     <= SEL_D;
            i_data_q   <= {WORD_SIZE{1'b0}};
            d_rdata_q  <= {WORD_SIZE{1'b0}};
            addr_err_q <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bad_q      <= bad_d;
            last_q     <= last_d;
            i_data_q   <= i_data_d;
            d_rdata_q  <= d_rdata_d;
            addr_err_q <= addr_err_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
        end
    end

    // Memory strobes come only from flops, so an async reset in ACCESS kills a write before its edge.
    assign mem_on_s     = (state_q == ST_ACCESS) && !bad_q;

    assign bus.MEM_ON   = mem_on_s;
    assign bus.MEM_W    = mem_on_s && we_q;
    assign bus.MEM_ADDR = addr_q;
    assign bus.MEM_DIN  = wdata_q;

    assign bus.I_ACK    = i_ack_q;
    assign bus.I_DATA   = i_data_q;
    assign bus.D_ACK    = d_ack_q;
    assign bus.D_RDATA  = d_rdata_q;
    assign bus.ADDR_ERR = addr_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 21-word behavioural Memory.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

    mem_port_arbiter #(.WORD_SIZE(16), .ADDR_MAX(20)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Memory: combinational read, write on the rising edge.
    logic [15:0] mem [0:20] = '{
        16'h1013, 16'h2222, 16'h0013, 16'h0013, 16'h0013, 16'h5555, 16'h0013,
        16'h0013, 16'h0013, 16'h0013, 16'h0013, 16'h0013, 16'h0013, 16'h0013,
        16'h0013, 16'h0013, 16'h0013, 16'h0013, 16'h0013, 16'h0013, 16'h0013
    };

    assign bus.MEM_DOUT = (bus.MEM_ON && (bus.MEM_ADDR <= 16'd20)) ? mem[bus.MEM_ADDR[4:0]] : 16'h0000;

    always @(posedge clk) begin
        if (bus.MEM_ON && bus.MEM_W && (bus.MEM_ADDR <= 16'd20))
            mem[bus.MEM_ADDR[4:0]] <= bus.MEM_DIN;
    end

    typedef struct {
        bit          is_d;
        logic [15:0] data;
        int          at;
        int          tag;
    } exp_t;

    exp_t sb_q[$];

    int checks  = 0;
    int errors  = 0;
    int on_cnt  = 0;
    int on_last = -1;
    int w_cnt   = 0;
    int ack_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.MEM_ON) begin
                on_cnt++;
                on_last = cyc;
            end
            if (bus.MEM_W) begin
                w_cnt++;
                check("mem_w_without_on", 32'(bus.MEM_ON), 32'd1);
            end
            if (bus.I_ACK || bus.D_ACK) begin
                ack_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: I_ACK=%0b D_ACK=%0b at cycle %0d, none expected",
                             bus.I_ACK, bus.D_ACK, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("t%0d_dual_ack", e.tag), 32'(bus.I_ACK && bus.D_ACK), 32'd0);
                    check($sformatf("t%0d_ack_sel", e.tag), 32'(bus.D_ACK), 32'(e.is_d));
                    check($sformatf("t%0d_ack_cycle", e.tag), 32'(cyc), 32'(e.at));
                    check($sformatf("t%0d_data", e.tag),
                          32'(e.is_d ? bus.D_RDATA : bus.I_DATA), 32'(e.data));
                end
            end
        end
    endtask

    task automatic wait_ack(input bit is_d, input int tag);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((is_d ? bus.D_ACK : bus.I_ACK) === 1'b1) begin
                if (is_d) bus.D_REQ = 1'b0; else bus.I_REQ = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL t%0d_ack_timeout: no ack within 12 cycles, expected one", tag);
        if (is_d) bus.D_REQ = 1'b0; else bus.I_REQ = 1'b0;
    endtask

    task automatic drive_req(input bit is_d, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata);
        if (is_d) begin
            bus.D_WE    = we;
            bus.D_ADDR  = addr;
            bus.D_WDATA = wdata;
            bus.D_REQ   = 1'b1;
        end else begin
            bus.I_ADDR  = addr;
            bus.I_REQ   = 1'b1;
        end
    endtask

    task automatic xact(input bit is_d, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_data,
                        input int tag, output int c);
        @(posedge clk);
        #1;
        c = cyc;
        sb_q.push_back('{is_d, exp_data, c + 2, tag});
        drive_req(is_d, we, addr, wdata);
        wait_ack(is_d, tag);
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_i_ack"},    32'(bus.I_ACK),    32'd0);
        check({p, "_d_ack"},    32'(bus.D_ACK),    32'd0);
        check({p, "_i_data"},   32'(bus.I_DATA),   32'd0);
        check({p, "_d_rdata"},  32'(bus.D_RDATA),  32'd0);
        check({p, "_addr_err"}, 32'(bus.ADDR_ERR), 32'd0);
        check({p, "_mem_w"},    32'(bus.MEM_W),    32'd0);
        check({p, "_mem_on"},   32'(bus.MEM_ON),   32'd0);
        check({p, "_mem_addr"}, 32'(bus.MEM_ADDR), 32'd0);
        check({p, "_mem_din"},  32'(bus.MEM_DIN),  32'd0);
    endtask

    initial begin
        int          c;
        int          on0;
        int          w0;
        int          a0;
        int          diffs;
        logic [15:0] snap [0:20];

        bus.I_REQ   = 1'b0;
        bus.I_ADDR  = 16'h0000;
        bus.D_REQ   = 1'b0;
        bus.D_WE    = 1'b0;
        bus.D_ADDR  = 16'h0000;
        bus.D_WDATA = 16'h0000;

        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst = 1'b0;

        // Fetch from address 0: MEM_ON only in the ACCESS cycle.
        on0 = on_cnt;
        xact(1'b0, 1'b0, 16'd0, 16'h0000, 16'h1013, 1, c);
        check("t1_on_count", 32'(on_cnt - on0), 32'd1);
        check("t1_on_cycle", 32'(on_last), 32'(c + 1));

        // Store 0xBEEF to 16: D_RDATA keeps its reset value, one write strobe.
        w0 = w_cnt;
        xact(1'b1, 1'b1, 16'd16, 16'hBEEF, 16'h0000, 2, c);
        check("t2_w_count", 32'(w_cnt - w0), 32'd1);
        check("t2_mem16", 32'(mem[16]), 32'h0000BEEF);

        xact(1'b1, 1'b0, 16'd16, 16'h0000, 16'hBEEF, 3, c);
        xact(1'b0, 1'b0, 16'd1,  16'h0000, 16'h2222, 4, c);

        // Out-of-range load: zero data, sticky error, no memory access.
        on0 = on_cnt;
        xact(1'b1, 1'b0, 16'd21, 16'h0000, 16'h0000, 5, c);
        check("t5_on_count", 32'(on_cnt - on0), 32'd0);
        check("t5_addr_err", 32'(bus.ADDR_ERR), 32'd1);

        // Out-of-range store to 0xFFFF must leave every word alone.
        for (int i = 0; i <= 20; i++) snap[i] = mem[i];
        on0 = on_cnt;
        w0  = w_cnt;
        xact(1'b1, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 6, c);
        diffs = 0;
        for (int i = 0; i <= 20; i++) if (mem[i] !== snap[i]) diffs++;
        check("t6_words_changed", 32'(diffs), 32'd0);
        check("t6_on_count", 32'(on_cnt - on0), 32'd0);
        check("t6_w_count", 32'(w_cnt - w0), 32'd0);

        xact(1'b0, 1'b0, 16'd5, 16'h0000, 16'h5555, 7, c);
        check("t7_addr_err_held", 32'(bus.ADDR_ERR), 32'd1);

        // Store to 17 aborted by a reset pulse inside ACCESS.
        a0 = ack_cnt;
        @(posedge clk);
        #1;
        drive_req(1'b1, 1'b1, 16'd17, 16'h1234);
        @(posedge clk);
        #1;
        check("abort_in_access_on", 32'(bus.MEM_ON), 32'd1);
        check("abort_in_access_w",  32'(bus.MEM_W),  32'd1);
        #1;
        rst       = 1'b1;
        bus.D_REQ = 1'b0;
        #1;
        check_all_zero("abort_rst");
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_ack_count", 32'(ack_cnt - a0), 32'd0);
        check("abort_mem17", 32'(mem[17]), 32'h00000013);

        // Tie straight after reset: grants alternate I, D, I, D three cycles apart.
        @(posedge clk);
        #1;
        c = cyc;
        sb_q.push_back('{1'b0, 16'h2222, c + 2,  8});
        sb_q.push_back('{1'b1, 16'hBEEF, c + 5,  9});
        sb_q.push_back('{1'b0, 16'h2222, c + 8,  10});
        sb_q.push_back('{1'b1, 16'hBEEF, c + 11, 11});
        drive_req(1'b0, 1'b0, 16'd1,  16'h0000);
        drive_req(1'b1, 1'b0, 16'd16, 16'h0000);
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_ack(1'b0, 8 + 2 * k);
                    if (k == 0) begin
                        @(posedge clk);
                        #1;
                        bus.I_REQ = 1'b1;
                    end
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_ack(1'b1, 9 + 2 * k);
                    if (k == 0) begin
                        @(posedge clk);
                        #1;
                        bus.D_REQ = 1'b1;
                    end
                end
            end
        join

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
